// File: rtl/dwconv_requant.sv
// dwconv_requant: rounding shift, ReLU clip and saturation of dwconv sums, tagged with position into an output FIFO.
// Optional macro DWCONV_REQ_RELU6_EN clips at 6<<FRAC_BITS (ReLU6) instead of the OUT_W signed maximum.
module dwconv_requant #(
   parameter int IN_W       = 21,
   parameter int OUT_W      = 16,
   parameter int CHANNELS   = 256,
   parameter int COLS       = 176,
   parameter int ROWS       = 128,
   parameter int FRAC_BITS  = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_sum,
   input  logic [4:0]       shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [7:0]       out_ch,
   output logic [7:0]       out_col,
   output logic [6:0]       out_row,
   output logic             out_last_px,
   output logic             overflow,
   output logic             frame_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = OUT_W + 24;
`ifdef DWCONV_REQ_RELU6_EN
   localparam bit R6 = 1'b1;
`else
   localparam bit R6 = 1'b0;
`endif
   localparam logic signed [IN_W:0] CLIP_MAX = R6 ? (IN_W+1)'(6 << FRAC_BITS) : (IN_W+1)'((1 << (OUT_W-1)) - 1);
   logic signed [IN_W:0] ext, rnd, r_d, r_q;
   logic s1_v_q, s2_v_q, s2_last_q;
   logic [OUT_W-1:0] s2_data_q, clip;
   logic [7:0] ch_q, col_q, s2_ch_q, s2_col_q;
   logic [6:0] row_q, s2_row_q;
   logic end_ch, end_col, end_row;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0] cnt_q;
   logic push, pop, full, ovf_q;
   always_comb begin
      ext = {in_sum[IN_W-1], in_sum};
      rnd = (shift == 5'd0) ? '0 : (IN_W+1)'(1) << (shift - 5'd1);
      r_d = (ext + rnd) >>> shift;
      clip = r_q[IN_W] ? '0 : (r_q > CLIP_MAX) ? CLIP_MAX[OUT_W-1:0] : r_q[OUT_W-1:0];
      end_ch = ch_q == 8'(CHANNELS-1);
      end_col = col_q == 8'(COLS-1);
      end_row = row_q == 7'(ROWS-1);
      out_valid = cnt_q != '0;
      full = cnt_q == (AW+1)'(FIFO_DEPTH);
      pop = out_valid && out_ready;
      push = s2_v_q && (!full || pop);
      {out_data, out_ch, out_col, out_row, out_last_px} = out_valid ? mem_q[rp_q] : '0;
      overflow = ovf_q;
      frame_done = s2_v_q && s2_last_q;
   end
   // counters hold the position of the next beat entering stage 2, so drops still advance them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q <= 1'b0;
         r_q <= '0;
         s2_v_q <= 1'b0;
         s2_data_q <= '0;
         s2_ch_q <= '0;
         s2_col_q <= '0;
         s2_row_q <= '0;
         s2_last_q <= 1'b0;
         ch_q <= '0;
         col_q <= '0;
         row_q <= '0;
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         s1_v_q <= in_valid;
         r_q <= r_d;
         s2_v_q <= s1_v_q;
         s2_data_q <= clip;
         if (s1_v_q) begin
            s2_ch_q <= ch_q;
            s2_col_q <= col_q;
            s2_row_q <= row_q;
            s2_last_q <= end_ch && end_col && end_row;
            ch_q <= end_ch ? '0 : ch_q + 8'd1;
            if (end_ch) col_q <= end_col ? '0 : col_q + 8'd1;
            if (end_ch && end_col) row_q <= end_row ? '0 : row_q + 7'd1;
         end
         if (push) wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         ovf_q <= ovf_q || (s2_v_q && full && !pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= {s2_data_q, s2_ch_q, s2_col_q, s2_row_q, s2_last_q};
   end
endmodule

// File: tb/tb_dwconv_requant.sv
// tb_dwconv_requant: directed vectors and corner sequences; a small-frame second instance covers frame wrap.
module tb_dwconv_requant;
`ifdef DWCONV_REQ_RELU6_EN
   localparam int CLIP = 1536;
`else
   localparam int CLIP = 32767;
`endif
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;
   logic in_valid, out_ready, out_valid, out_last_px, overflow, frame_done;
   logic [20:0] in_sum;
   logic [4:0] shift;
   logic [15:0] out_data;
   logic [7:0] out_ch, out_col;
   logic [6:0] out_row;
   logic b_in_valid, b_out_valid, b_out_last_px, b_overflow, b_frame_done;
   logic [20:0] b_in_sum;
   logic [15:0] b_out_data;
   logic [7:0] b_out_ch, b_out_col;
   logic [6:0] b_out_row;
   int tests = 0, fails = 0, fd = 0;
   dwconv_requant dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .shift(shift),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_col(out_col),
      .out_row(out_row), .out_last_px(out_last_px), .overflow(overflow), .frame_done(frame_done));
   dwconv_requant #(.CHANNELS(4), .COLS(3), .ROWS(2)) dutb (.clk(clk), .rst(rst), .in_valid(b_in_valid),
      .in_sum(b_in_sum), .shift(5'd0), .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
      .out_ch(b_out_ch), .out_col(b_out_col), .out_row(b_out_row), .out_last_px(b_out_last_px),
      .overflow(b_overflow), .frame_done(b_frame_done));
   typedef struct { logic [4:0] sh; int sum; int exp; } vec_t;
   vec_t vt [14];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   initial begin
      vt[0] = '{5'd8, 384, 2};
      vt[1] = '{5'd8, 383, 1};
      vt[2] = '{5'd0, 77, 77};
      vt[3] = '{5'd8, -500, 0};
      vt[4] = '{5'd0, 1048575, CLIP};
      vt[5] = '{5'd4, -8, 0};
      vt[6] = '{5'd1, 3, 2};
      vt[7] = '{5'd1, -3, 0};
      vt[8] = '{5'd20, -1048576, 0};
      vt[9] = '{5'd20, 1048575, 1};
      vt[10] = '{5'd4, 24, 2};
      vt[11] = '{5'd4, 23, 1};
      vt[12] = '{5'd0, 32768, CLIP};
      vt[13] = '{5'd0, 1537, (CLIP == 1536) ? 1536 : 1537};
      in_valid = 0; in_sum = '0; shift = '0; out_ready = 0; b_in_valid = 0; b_in_sum = '0;
      #2 rst = 1;
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_tags", {out_ch, out_col, out_row, out_last_px}, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_fd", frame_done, 0);
      rst = 0;
      out_ready = 1;
      for (int i = 0; i < 14; i++) begin
         in_valid = 1; shift = vt[i].sh; in_sum = 21'(vt[i].sum);
         tick(); in_valid = 0; tick(); tick();
         chk("vec_valid", out_valid, 1);
         chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
         tick();
      end
      shift = 0;
      rst = 1; tick(); rst = 0;
      for (int c = 0; c < 302; c++) begin
         in_valid = c < 300; in_sum = 21'(c);
         tick();
         if (c < 2) chk("strm_lat", out_valid, 0);
         else begin
            chk("strm_valid", out_valid, 1);
            chk("strm_data", out_data, c - 2);
            chk("strm_ch", out_ch, (c - 2) % 256);
            chk("strm_col", out_col, (c - 2) / 256);
         end
      end
      in_valid = 0;
      rst = 1; tick(); rst = 0;
      out_ready = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; in_sum = 21'(100 + i); tick();
      end
      in_valid = 0; tick(); tick();
      chk("ovf_set", overflow, 1);
      chk("ovf_head", out_data, 100);
      tick();
      chk("ovf_hold_valid", out_valid, 1);
      chk("ovf_hold_data", out_data, 100);
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, 100 + k);
         chk("drain_ch", out_ch, k);
         tick();
      end
      chk("drain_empty", out_valid, 0);
      in_valid = 1; in_sum = 21'(55); tick(); in_valid = 0; tick(); tick();
      chk("after_ovf_valid", out_valid, 1);
      chk("after_ovf_ch", out_ch, 10);
      chk("after_ovf_data", out_data, 55);
      tick();
      chk("ovf_sticky", overflow, 1);
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_sum = 21'(200 + i); tick();
      end
      in_valid = 0; tick(); tick();
      chk("mid_queued", out_valid, 1);
      chk("mid_head_ch", out_ch, 11);
      #2 rst = 1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_data", out_data, 0);
      @(posedge clk); #1;
      rst = 0;
      in_valid = 1; in_sum = 21'(9); out_ready = 1;
      tick(); in_valid = 0; tick(); tick();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_tags", {out_ch, out_col, out_row}, 0);
      chk("post_rst_data", out_data, 9);
      tick();
      for (int c = 0; c < 27; c++) begin
         b_in_valid = c < 25; b_in_sum = 21'(c);
         tick();
         if (b_frame_done) fd++;
         chk("fd_timing", b_frame_done, c == 24);
         if (c == 25) begin
            chk("last_valid", b_out_valid, 1);
            chk("last_px", b_out_last_px, 1);
            chk("last_tags", {b_out_ch, b_out_col, b_out_row}, {8'd3, 8'd2, 7'd1});
            chk("last_data", b_out_data, 23);
         end
         if (c == 26) begin
            chk("wrap_valid", b_out_valid, 1);
            chk("wrap_px", b_out_last_px, 0);
            chk("wrap_tags", {b_out_ch, b_out_col, b_out_row}, 0);
         end
      end
      b_in_valid = 0;
      chk("fd_count", fd, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dwconv_requant.md
# dwconv_requant

Downstream stage of the depthwise convolution block. Takes the 21-bit per-channel accumulator stream (`sum` and `out_valid` of the dwconv stage) and applies a rounding arithmetic right shift, ReLU clipping and 16-bit saturation. Each result is tagged with channel, column and row position and buffered in a small FIFO behind a valid/ready handshake. The upstream stage cannot be stalled, so the FIFO absorbs short downstream stalls and any loss is flagged.

## Interface
- `IN_W`, 21, accumulator width
- `OUT_W`, 16, output activation width
- `CHANNELS`, 256, channels per pixel (beats per pixel)
- `COLS`, 176, pixels per row
- `ROWS`, 128, rows per frame
- `FRAC_BITS`, 8, fractional bits of the output format
- `FIFO_DEPTH`, 8, output FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  one accumulator beat present
- `in_sum`  in  IN_W  signed accumulator
- `shift`  in  5  right-shift amount, 0..20; static within a frame
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  OUT_W  signed result, always ≥0
- `out_ch`  out  8  channel index of head
- `out_col`  out  8  column index of head
- `out_row`  out  7  row index of head
- `out_last_px`  out  1  head is channel CHANNELS-1 of the last pixel of the frame
- `overflow`  out  1  sticky: a beat was dropped
- `frame_done`  out  1  one-cycle pulse when the last beat of a frame leaves stage 2

## Operation
- **Stage 1 (registered):**
  - r = (in_sum + (shift ? 1<<(shift-1) : 0)) >>> shift.
  - Computed in IN_W+1 bits with sign extension, so no wrap.
  - Round half up toward +inf.
- **Stage 2 (registered):**
  - If r < 0, the result is 0.
  - If r > CLIP_MAX, the result is CLIP_MAX.
  - Otherwise the result is r.
  - Stage 2 also attaches the position counters (ch, col, row) to the beat.
- **Position counters:**
  - Advance on every stage-2 valid beat, whether or not it is written to the FIFO.
  - ch wraps CHANNELS-1→0 and then increments col.
  - col wraps COLS-1→0 and then increments row.
  - row wraps ROWS-1→0; `frame_done` pulses on this wrap.
- **FIFO push:** the stage-2 valid beat is pushed. If the FIFO is full and no pop occurs that cycle, the beat is dropped and `overflow` is set to 1. `overflow` holds until `rst`.
- **Simultaneous push and pop when full:** both occur; no drop.
- **Pop:** occurs when `out_valid && out_ready`.
- **FIFO head outputs:** `out_data`, tags and `out_last_px` are driven from the head entry and hold stable while `out_valid && !out_ready`.
- **FIFO storage:** circular buffer with read/write pointers and a count.
- **No FSM beyond the counters:** the block is stream-driven; `in_valid` gaps of any length are allowed.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`/`out_col`/`out_row`=0, `out_last_px`=0, `overflow`=0, `frame_done`=0.
- Reset clears the FIFO, all counters and both stage valids.
- Reset mid-frame: all in-flight beats are discarded. The next beat after release is position (0,0,0).
- Latency:
  - Beat sampled at edge N is valid in stage 2 after edge N+1.
  - It is written to the FIFO at edge N+2.
  - If the FIFO was empty, `out_valid`=1 in the cycle after edge N+2 (2 cycles from sample to visible output).
- Throughput: 1 beat/cycle when `out_ready`=1 continuously. `out_valid` never drops between back-to-back beats.
- `frame_done` is asserted in the same cycle the last frame beat is in stage 2. It is independent of FIFO state.

## Configuration
- `DWCONV_REQ_RELU6_EN`:
  - Defined: CLIP_MAX = 6<<FRAC_BITS = 1536. This gives ReLU6 in Q(OUT_W-FRAC_BITS).FRAC_BITS.
  - Undefined: CLIP_MAX = 2^(OUT_W-1)-1 = 32767. This gives plain ReLU with saturation.

## Test plan
- **Rounding:** shift=8, `in_sum`=384 → `out_data`=2. Also: `in_sum`=383 → 1; shift=0, `in_sum`=77 → 77.
- **ReLU and saturation:**
  - `in_sum`=-500 → 0.
  - shift=0, `in_sum`=1048575 → 32767 without the macro, 1536 with it.
  - shift=4, `in_sum`=-8 → 0.
- **Latency and streaming:** 300 consecutive beats with `out_ready`=1.
  - First `out_valid` appears 2 cycles after the first sample.
  - No bubbles.
  - `out_ch` runs 0..255, then 0..43 with `out_col`=1.
- **Backpressure overflow:** `out_ready`=0, FIFO_DEPTH=8, 10 consecutive beats.
  - 8 entries are held and `overflow`=1.
  - Raising `out_ready` drains beats 1..8 in order.
  - The next input beat carries `out_ch`=10, not 8.
- **Frame wrap:** stream CHANNELS×COLS×ROWS beats.
  - The last popped beat has `out_last_px`=1, `out_row`=127, `out_col`=175.
  - `frame_done` pulses once.
  - The next beat is tagged (0,0,0).
- **Reset mid-frame:** assert `rst` with 5 entries queued.
  - `out_valid`=0 immediately (asynchronous), `overflow`=0.
  - The first beat after release is tagged ch=0, col=0, row=0.
